// File: rtl/bcd_sevenseg_pkg.sv
// Shared seven-segment constants, accumulator FSM encoding and BCD-to-segment decode.
// Segment patterns are active-low, bit order a..g from MSB to LSB.
package bcd_sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } acc_state_t;

  // Non-BCD codes show "0" so a corrupted digit never blanks the display.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-button conditioner: synchroniser, stability counter, one-cycle rising-edge pulse.
// Pulse lags the raw edge by SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles; no backpressure.
module sw_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_level_q;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_sw};
      r_level_q <= r_level;
      // Any agreement with the accepted level restarts the stability window.
      if (w_synced != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= w_synced;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/bcd_accum_sevenseg.sv
// Adds step_bcd to an N-digit BCD total on each debounced press, one digit per cycle.
// Press to total: NUM_DIGITS+2 cycles, seg_out one later; one press queues while busy, more are dropped.
module bcd_accum_sevenseg #(
  parameter int NUM_DIGITS      = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SATURATE        = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sw,
  input  logic [4*NUM_DIGITS-1:0] step_bcd,
  output logic [4*NUM_DIGITS-1:0] total_bcd,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    busy,
  output logic                    overflow
);
  import bcd_sevenseg_pkg::*;

  localparam int            W         = 4 * NUM_DIGITS;
  localparam int            IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [W-1:0]  ALL_NINES = {NUM_DIGITS{4'h9}};

  acc_state_t                r_state;
  acc_state_t                w_state_nxt;
  logic                      w_press;
  logic                      w_start;
  logic                      w_commit;
  logic [W-1:0]              w_step_clamp;
  logic [3:0]                w_tot_dig;
  logic [3:0]                w_stp_dig;
  logic [4:0]                w_sum;
  logic                      w_sum_gt9;
  logic [3:0]                w_res_dig;
  logic [W-1:0]              r_step;
  logic [W-1:0]              r_work;
  logic [W-1:0]              r_total;
  logic [7*NUM_DIGITS-1:0]   r_seg;
  logic [IW-1:0]             r_idx;
  logic                      r_carry;
  logic                      r_pending;
  logic                      r_busy;
  logic                      r_ovf;

  sw_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_sw   (sw),
    .o_press(w_press)
  );

  always_comb begin
    w_step_clamp = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_step_clamp[4*i +: 4] = (step_bcd[4*i +: 4] > 4'd9) ? 4'd9 : step_bcd[4*i +: 4];
  end

  assign w_tot_dig = r_total[4*r_idx +: 4];
  assign w_stp_dig = r_step[4*r_idx +: 4];
  assign w_sum     = 5'(w_tot_dig) + 5'(w_stp_dig) + 5'(r_carry);
  assign w_sum_gt9 = (w_sum > 5'd9);
  assign w_res_dig = w_sum_gt9 ? 4'(w_sum - 5'd10) : w_sum[3:0];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press || r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = ADD;
        end
      end
      ADD: begin
        if (r_idx == LAST_IDX) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit = 1'b1;
        if (r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = ADD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step    <= '0;
      r_work    <= '0;
      r_total   <= '0;
      r_seg     <= {NUM_DIGITS{SEG_0}};
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_start) begin
        r_step  <= w_step_clamp;
        r_idx   <= '0;
        r_carry <= 1'b0;
      end else if (r_state == ADD) begin
        r_work[4*r_idx +: 4] <= w_res_dig;
        r_carry              <= w_sum_gt9;
        r_idx                <= r_idx + IW'(1);
      end
      // A press that coincides with consuming the queued one becomes the new queued press.
      if (w_start) r_pending <= r_pending & w_press;
      else         r_pending <= r_pending | (w_press & (r_state != IDLE));
      if (w_commit) begin
        r_total <= (r_carry && (SATURATE != 0)) ? ALL_NINES : r_work;
        if (r_carry) r_ovf <= 1'b1;
      end
      r_busy <= (w_state_nxt != IDLE);
      for (int i = 0; i < NUM_DIGITS; i++)
        r_seg[7*i +: 7] <= bcd_to_seg(r_total[4*i +: 4]);
    end
  end

  assign total_bcd = r_total;
  assign seg_out   = r_seg;
  assign busy      = r_busy;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_accum_sevenseg.sv
// Bench for bcd_accum_sevenseg: wrap and saturate 2-digit instances share stimulus,
// an 8-digit fast-debounce instance covers press queuing and long carry chains.
module tb_bcd_accum_sevenseg;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw_ab, sw_c;
  logic [7:0]  step_ab;
  logic [31:0] step_c;
  logic [7:0]  total_a, total_b;
  logic [13:0] seg_a, seg_b;
  logic        busy_a, busy_b, ovf_a, ovf_b;
  logic [31:0] total_c;
  logic [55:0] seg_c;
  logic        busy_c, ovf_c;

  always #5 clk = ~clk;

  bcd_accum_sevenseg #(.NUM_DIGITS(2), .DEBOUNCE_CYCLES(4), .SATURATE(0), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .reset(reset), .sw(sw_ab), .step_bcd(step_ab),
    .total_bcd(total_a), .seg_out(seg_a), .busy(busy_a), .overflow(ovf_a));

  bcd_accum_sevenseg #(.NUM_DIGITS(2), .DEBOUNCE_CYCLES(4), .SATURATE(1), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .reset(reset), .sw(sw_ab), .step_bcd(step_ab),
    .total_bcd(total_b), .seg_out(seg_b), .busy(busy_b), .overflow(ovf_b));

  bcd_accum_sevenseg #(.NUM_DIGITS(8), .DEBOUNCE_CYCLES(2), .SATURATE(0), .SYNC_STAGES(2)) u_dut_c (
    .clk(clk), .reset(reset), .sw(sw_c), .step_bcd(step_c),
    .total_bcd(total_c), .seg_out(seg_c), .busy(busy_c), .overflow(ovf_c));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  longint m_a, m_b, m_c;
  logic   o_a, o_b, o_c;

  typedef struct {
    logic [7:0] step;
    logic [7:0] tot_a;
    logic       ovf_a;
    logic [7:0] tot_b;
    logic       ovf_b;
  } vec_t;
  vec_t tab [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2dec(input logic [31:0] v, input int n);
    longint r = 0;
    for (int i = n - 1; i >= 0; i--) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [31:0] dec2bcd(input longint x, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_seg(input logic [31:0] bcd, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[7*i +: 7] = seg_tab[int'(bcd[4*i +: 4])];
    return r;
  endfunction

  task automatic model_add(inout longint m, inout logic o, input longint st, input int n, input bit sat);
    longint lim, s;
    lim = pow10(n);
    s   = m + st;
    if (s >= lim) begin
      o = 1'b1;
      s = sat ? lim - 1 : s - lim;
    end
    m = s;
  endtask

  task automatic press_ab(input int hi, input int lo);
    sw_ab = 1'b1;
    repeat (hi) tick();
    sw_ab = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic press_c(input int hi, input int lo);
    sw_c = 1'b1;
    repeat (hi) tick();
    sw_c = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic add_ab(input logic [7:0] st);
    model_add(m_a, o_a, bcd2dec({24'h0, st}, 2), 2, 1'b0);
    model_add(m_b, o_b, bcd2dec({24'h0, st}, 2), 2, 1'b1);
  endtask

  task automatic check_ab(input string tag);
    check({tag, "_tot_a"}, 64'(total_a), 64'(dec2bcd(m_a, 2)));
    check({tag, "_seg_a"}, 64'(seg_a), exp_seg(dec2bcd(m_a, 2), 2));
    check({tag, "_ovf_a"}, 64'(ovf_a), 64'(o_a));
    check({tag, "_tot_b"}, 64'(total_b), 64'(dec2bcd(m_b, 2)));
    check({tag, "_seg_b"}, 64'(seg_b), exp_seg(dec2bcd(m_b, 2), 2));
    check({tag, "_ovf_b"}, 64'(ovf_b), 64'(o_b));
  endtask

  task automatic check_c(input string tag);
    check({tag, "_tot_c"}, 64'(total_c), 64'(dec2bcd(m_c, 8)));
    check({tag, "_seg_c"}, 64'(seg_c), exp_seg(dec2bcd(m_c, 8), 8));
    check({tag, "_ovf_c"}, 64'(ovf_c), 64'(o_c));
  endtask

  initial begin
    int busy_cnt;
    reset = 1'b0; sw_ab = 1'b0; sw_c = 1'b0; step_ab = '0; step_c = '0;
    m_a = 0; m_b = 0; m_c = 0; o_a = 0; o_b = 0; o_c = 0;

    tab[0] = '{8'h25, 8'h50, 1'b0, 8'h50, 1'b0};
    tab[1] = '{8'h25, 8'h75, 1'b0, 8'h75, 1'b0};
    tab[2] = '{8'h25, 8'h00, 1'b1, 8'h99, 1'b1};
    tab[3] = '{8'h3F, 8'h39, 1'b1, 8'h99, 1'b1};
    tab[4] = '{8'h01, 8'h40, 1'b1, 8'h99, 1'b1};
    tab[5] = '{8'hF0, 8'h30, 1'b1, 8'h99, 1'b1};

    // Reset state
    repeat (3) tick();
    check("rst_tot_a", 64'(total_a), 64'h0);
    check("rst_seg_a", 64'(seg_a), 64'({7'b0000001, 7'b0000001}));
    check("rst_busy_a", 64'(busy_a), 64'h0);
    check("rst_ovf_a", 64'(ovf_a), 64'h0);
    check("rst_tot_c", 64'(total_c), 64'h0);
    check("rst_seg_c", 64'(seg_c), 64'({8{7'b0000001}}));
    reset = 1'b1;
    repeat (2) tick();

    // Single press latency: pulse 5 edges after sw rises, total 4 edges after the pulse
    step_ab  = 8'h25;
    sw_ab    = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (busy_a) busy_cnt++;
      if (k == 10) sw_ab = 1'b0;
      if (k == 7)  check("t2_busy_on", 64'(busy_a), 64'h1);
      if (k == 9)  check("t2_tot_early", 64'(total_a), 64'h0);
      if (k == 10) check("t2_tot_on_time", 64'(total_a), 64'h25);
      if (k == 10) check("t2_seg_lag", 64'(seg_a), 64'({7'b0000001, 7'b0000001}));
      if (k == 11) check("t2_seg", 64'(seg_a), 64'({7'b0010010, 7'b0100100}));
    end
    check("t2_busy_cycles", 64'(busy_cnt), 64'd3);
    repeat (10) tick();
    add_ab(8'h25);
    check_ab("t2");

    // Repeated adds: wrap vs saturate, clamped step digits
    for (int i = 0; i < 6; i++) begin
      step_ab = tab[i].step;
      press_ab(8, 14);
      add_ab(tab[i].step);
      check($sformatf("t3_%0d_tot_a", i), 64'(total_a), 64'(tab[i].tot_a));
      check($sformatf("t3_%0d_ovf_a", i), 64'(ovf_a), 64'(tab[i].ovf_a));
      check($sformatf("t3_%0d_tot_b", i), 64'(total_b), 64'(tab[i].tot_b));
      check($sformatf("t3_%0d_ovf_b", i), 64'(ovf_b), 64'(tab[i].ovf_b));
      check($sformatf("t3_%0d_seg_a", i), 64'(seg_a), exp_seg({24'h0, tab[i].tot_a}, 2));
    end

    // Bounce shorter than the debounce window must not add
    step_ab = 8'h12;
    repeat (5) begin
      sw_ab = 1'b1; repeat (3) tick();
      sw_ab = 1'b0; repeat (3) tick();
    end
    repeat (10) tick();
    check("t4_bounce_tot_a", 64'(total_a), 64'h30);
    check("t4_bounce_busy_a", 64'(busy_a), 64'h0);
    press_ab(6, 16);
    add_ab(8'h12);
    check("t4_clean_tot_a", 64'(total_a), 64'h42);
    check_ab("t4");

    // Reset during ADD digit 1
    step_ab = 8'h33;
    sw_ab   = 1'b1;
    repeat (8) tick();
    check("t6_busy_before", 64'(busy_a), 64'h1);
    reset = 1'b0;
    sw_ab = 1'b0;
    #1;
    check("t6_tot_a", 64'(total_a), 64'h0);
    check("t6_seg_a", 64'(seg_a), 64'({7'b0000001, 7'b0000001}));
    check("t6_busy_a", 64'(busy_a), 64'h0);
    check("t6_ovf_a", 64'(ovf_a), 64'h0);
    check("t6_ovf_b", 64'(ovf_b), 64'h0);
    repeat (2) tick();
    reset = 1'b1;
    m_a = 0; m_b = 0; m_c = 0; o_a = 0; o_b = 0; o_c = 0;
    repeat (3) tick();
    check("t6_no_resume_a", 64'(total_a), 64'h0);
    step_ab = 8'h47;
    press_ab(8, 14);
    add_ab(8'h47);
    check_ab("t6_after");

    // Three presses 4 cycles apart on the 8-digit instance: one runs, one queues, one drops
    step_c = 32'h0000_0009;
    sw_c   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      sw_c = (k < 10) && ((k % 4) < 2);
      if (k == 14) check("t5_first_add", 64'(total_c), 64'h9);
      if (k == 22) check("t5_second_pending", 64'(total_c), 64'h9);
      if (k == 23) check("t5_second_add", 64'(total_c), 64'h18);
    end
    model_add(m_c, o_c, 9, 8, 1'b0);
    model_add(m_c, o_c, 9, 8, 1'b0);
    check_c("t5");

    // Randomised adds against the decimal model
    for (int i = 0; i < 20; i++) begin
      step_ab = 8'($urandom);
      press_ab(int'($urandom_range(6, 10)), int'($urandom_range(12, 18)));
      add_ab(step_ab);
      check_ab($sformatf("rnd_ab%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      step_c = $urandom;
      press_c(int'($urandom_range(3, 6)), int'($urandom_range(18, 24)));
      model_add(m_c, o_c, bcd2dec(step_c, 8), 8, 1'b0);
      check_c($sformatf("rnd_c%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
